// File: rtl/axis_cpu_ctl.sv
// Control and debug block for the AXIS soft CPU: memory-programming pointers, the
// RUN/HALT/STEP/PROG execution-mode FSM and register snapshots on the debug stream.
module axis_cpu_ctl #(
  parameter int unsigned CODE_ADDR_WIDTH = 10,
  parameter int unsigned TBL_ADDR_WIDTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH  = 4,
  parameter int unsigned STEP_CNT_WIDTH  = 16,
  parameter int unsigned NUM_DBG_WORDS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_ADDR_WIDTH-1:0]     reg_addr,
  input  logic [31:0]                   reg_data,
  input  logic                          reg_strb,
  output logic [CODE_ADDR_WIDTH-1:0]    inst_wr_addr,
  output logic                          inst_wr_en,
  output logic [TBL_ADDR_WIDTH-1:0]     jmp_off_wr_addr,
  output logic                          jmp_off_wr_en,
  output logic [TBL_ADDR_WIDTH-1:0]     imm_wr_addr,
  output logic                          imm_wr_en,
  output logic                          cpu_hold,
  output logic                          cpu_run_en,
  input  logic                          inst_retire,
  input  logic [32*NUM_DBG_WORDS-1:0]   snap_data,
  output logic [1:0]                    mode,
  output logic                          prog_ovf,
  output logic [31:0]                   dbg_TDATA,
  output logic                          dbg_TVALID,
  input  logic                          dbg_TREADY,
  output logic                          dbg_TLAST
);

  localparam int unsigned IdxW = (NUM_DBG_WORDS > 1) ? $clog2(NUM_DBG_WORDS) : 1;

  localparam logic [REG_ADDR_WIDTH-1:0] AddrProg   = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0] AddrInst   = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] AddrJmpOff = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0] AddrImm    = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0] AddrMode   = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0] AddrStep   = REG_ADDR_WIDTH'(5);
  localparam logic [REG_ADDR_WIDTH-1:0] AddrDbgReq = REG_ADDR_WIDTH'(6);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHalt = 2'd1,
    StStep = 2'd2,
    StProg = 2'd3
  } mode_e;

  mode_e                      mode_q;
  logic [STEP_CNT_WIDTH-1:0]  step_cnt_q;
  logic [CODE_ADDR_WIDTH-1:0] inst_ptr_q;
  logic [TBL_ADDR_WIDTH-1:0]  jmp_ptr_q;
  logic [TBL_ADDR_WIDTH-1:0]  imm_ptr_q;
  logic                       prog_ovf_q;
  logic                       busy_q;
  logic [IdxW-1:0]            idx_q;
  logic [31:0]                shadow_q [NUM_DBG_WORDS];

  logic in_prog, wr_prog, wr_mode, wr_step, wr_dbg;
  logic prog_enter, step_wr, mode_wr, step_last, retire_cnt, step_done, snap_trig, last_beat;
  logic [STEP_CNT_WIDTH-1:0] step_val;

  always_comb begin
    in_prog    = (mode_q == StProg);
    wr_prog    = reg_strb && (reg_addr == AddrProg);
    wr_mode    = reg_strb && (reg_addr == AddrMode);
    wr_step    = reg_strb && (reg_addr == AddrStep);
    wr_dbg     = reg_strb && (reg_addr == AddrDbgReq);
    step_val   = reg_data[STEP_CNT_WIDTH-1:0];
    prog_enter = wr_prog && reg_data[0];
    step_wr    = wr_step && !in_prog;
    mode_wr    = wr_mode && !in_prog && !reg_data[1];
    step_last  = (mode_q == StStep) && (step_cnt_q == STEP_CNT_WIDTH'(1));
    // Any MODE/STEP/PROG-entry write in the retire cycle takes priority over counting it.
    retire_cnt = (mode_q == StStep) && inst_retire && !wr_step && !wr_mode && !prog_enter;
    step_done  = retire_cnt && step_last;
    snap_trig  = (step_done || (wr_dbg && !in_prog)) && !busy_q;
    last_beat  = (idx_q == IdxW'(NUM_DBG_WORDS - 1));
  end

  assign inst_wr_en      = reg_strb && (reg_addr == AddrInst) && in_prog;
  assign jmp_off_wr_en   = reg_strb && (reg_addr == AddrJmpOff) && in_prog;
  assign imm_wr_en       = reg_strb && (reg_addr == AddrImm) && in_prog;
  assign inst_wr_addr    = inst_ptr_q;
  assign jmp_off_wr_addr = jmp_ptr_q;
  assign imm_wr_addr     = imm_ptr_q;
  assign prog_ovf        = prog_ovf_q;
  assign mode            = mode_q;
  assign cpu_hold        = in_prog;
  // Fetch stops in the very cycle the last stepped instruction retires.
  assign cpu_run_en      = (mode_q == StRun) ||
                           ((mode_q == StStep) && !(inst_retire && step_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= StRun;
      step_cnt_q <= '0;
      inst_ptr_q <= '0;
      jmp_ptr_q  <= '0;
      imm_ptr_q  <= '0;
      prog_ovf_q <= 1'b0;
    end else begin
      if (prog_enter)                mode_q <= StProg;
      else if (wr_prog && in_prog)   mode_q <= reg_data[1] ? StHalt : StRun;
      else if (step_wr)              mode_q <= (step_val != '0) ? StStep : StHalt;
      else if (mode_wr)              mode_q <= reg_data[0] ? StHalt : StRun;
      else if (step_done)            mode_q <= StHalt;

      if (step_wr)         step_cnt_q <= step_val;
      else if (retire_cnt) step_cnt_q <= step_cnt_q - STEP_CNT_WIDTH'(1);

      if (prog_enter) begin
        inst_ptr_q <= '0;
        jmp_ptr_q  <= '0;
        imm_ptr_q  <= '0;
        prog_ovf_q <= 1'b0;
      end else begin
        if (inst_wr_en) begin
          inst_ptr_q <= inst_ptr_q + CODE_ADDR_WIDTH'(1);
          if (&inst_ptr_q) prog_ovf_q <= 1'b1;
        end
        if (jmp_off_wr_en) begin
          jmp_ptr_q <= jmp_ptr_q + TBL_ADDR_WIDTH'(1);
          if (&jmp_ptr_q) prog_ovf_q <= 1'b1;
        end
        if (imm_wr_en) begin
          imm_ptr_q <= imm_ptr_q + TBL_ADDR_WIDTH'(1);
          if (&imm_ptr_q) prog_ovf_q <= 1'b1;
        end
      end
    end
  end

  // Snapshot engine runs independently of mode so an in-flight stream always completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
      for (int k = 0; k < NUM_DBG_WORDS; k++) shadow_q[k] <= '0;
    end else if (snap_trig) begin
      busy_q <= 1'b1;
      idx_q  <= '0;
      for (int k = 0; k < NUM_DBG_WORDS; k++) shadow_q[k] <= snap_data[32*k +: 32];
    end else if (busy_q && dbg_TREADY) begin
      if (last_beat) begin
        busy_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

  assign dbg_TVALID = busy_q;
  assign dbg_TLAST  = busy_q && last_beat;
  assign dbg_TDATA  = busy_q ? shadow_q[idx_q] : 32'h0;

endmodule
